div_iter_unit: RTL and testbench



---
 rtl/div_iter_unit.sv | 121 ++++++++++++
 tb/tb_div_iter_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// div_iter_unit: multi-cycle restoring divider for DIV/DIVU.
// It accepts one request through the start_i/ready_o handshake and computes one
// quotient bit per cycle, MSB first. The result is {remainder, quotient}.
module div_iter_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned    CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     dvd_q, dvs_q, rem_q, quo_q;
    logic                 neg_quo_q, neg_rem_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   result_q;

    logic                 accept, div_by_zero, last_step, q_bit;
    logic [WIDTH-1:0]     abs1, abs2, rem_nx, quo_nx, rem_fin, quo_fin;
    logic [WIDTH:0]       shifted, diff;

    // Operand conditioning and one restoring-division step
    always_comb begin
        accept      = (state == IDLE) && start_i && !annul_i;
        div_by_zero = (opdata2_i == '0);
        abs1        = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2        = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        // The partial remainder is always below the divisor. Because of that,
        // WIDTH+1 bits can hold the difference, and its top bit is the borrow.
        shifted     = {rem_q, dvd_q[WIDTH-1]};
        diff        = shifted - {1'b0, dvs_q};
        q_bit       = ~diff[WIDTH];
        rem_nx      = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nx      = {quo_q[WIDTH-2:0], q_bit};
        rem_fin     = neg_rem_q ? -rem_nx : rem_nx;
        quo_fin     = neg_quo_q ? -quo_nx : quo_nx;
        last_step   = (cnt_q == LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = div_by_zero ? DIVZERO : BUSY;
            DIVZERO: state_nx = annul_i ? IDLE : DONE;
            BUSY:    begin
                if (annul_i)        state_nx = IDLE;
                else if (last_step) state_nx = DONE;
            end
            DONE:    if (!start_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    result_q <= '0;
                    if (accept && !div_by_zero) begin
                        dvd_q     <= abs1;
                        dvs_q     <= abs2;
                        neg_quo_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_q <= signed_div_i && opdata1_i[WIDTH-1];
                        rem_q     <= '0;
                        quo_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                DIVZERO: result_q <= '0;
                BUSY: begin
                    if (annul_i) begin
                        cnt_q <= '0;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        dvd_q <= dvd_q << 1;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_step) result_q <= {rem_fin, quo_fin};
                    end
                end
                DONE: if (!start_i) result_q <= '0;
                default: result_q <= '0;
            endcase
        end
    end

    // Outputs come straight from registered state
    always_comb begin
        ready_o  = (state == DONE);
        result_o = result_q;
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Testbench for div_iter_unit. Stimulus tasks push the expected results into a
// scoreboard queue. An independent monitor pops one entry on every rising edge
// of ready_o and compares it with result_o.
module tb_div_iter_unit;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            signed_div = 1'b0;
    logic [W-1:0]    op1 = '0;
    logic [W-1:0]    op2 = '0;
    logic            start = 1'b0;
    logic            annul = 1'b0;
    logic [2*W-1:0]  result;
    logic            ready;

    int              n_vec  = 0;
    int              n_fail = 0;
    logic [2*W-1:0]  sb[$];
    logic            prev_ready = 1'b0;
    logic            mon_en = 1'b0;

    always #5 clk = ~clk;

    div_iter_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: score each new result and check that result_o is zero while idle
    always @(negedge clk) begin
        if (mon_en) begin
            if (ready && !prev_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", {63'd0, ready}, 64'd0);
                end else begin
                    check("result", result, sb.pop_front());
                end
            end
            if (!ready && result !== '0) check("result_zero_when_not_ready", result, 64'd0);
            prev_ready <= ready;
        end
    end

    // Issue one operation. Check the handshake latency, the hold behaviour
    // while start stays high, and the clear after start drops.
    task automatic run_op(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int lat, input int hold);
        int cycles;
        @(negedge clk);
        signed_div = sd; op1 = a; op2 = b; start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);                       // accepting edge E0
        #1;
        op1 = $urandom; op2 = $urandom; signed_div = ~sd;  // must be ignored
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!ready && cycles < 100);
        check("latency_edges", 64'(cycles), 64'(lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_ready", {63'd0, ready}, 64'd1);
            check("hold_result", result, exp);
        end
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("drop_ready", {63'd0, ready}, 64'd0);
        check("drop_result", result, 64'd0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Unsigned 100 / 7 -> q=14, r=2
        run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, W, 0);
        // Signed cases: quotient truncates toward zero, remainder takes the dividend's sign
        run_op(1'b1, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, W, 0);
        run_op(1'b1, 32'd7, -32'sd2, 64'h00000001_FFFFFFFD, W, 0);
        run_op(1'b1, -32'sd8, -32'sd2, 64'h00000000_00000004, W, 0);
        // Signed overflow wraps; the unsigned interpretation gives q=0, r=dividend
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, W, 0);
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, W, 0);
        // Divide by zero: result 0 after one edge, held while start stays high
        run_op(1'b0, 32'd5, 32'd0, 64'd0, 1, 3);

        // Annul at BUSY cycle 10: no result is produced
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); @(negedge clk);
        annul = 1'b0; start = 1'b0;
        cyc = 0;
        while (!ready && cyc < 40) begin @(posedge clk); @(negedge clk); cyc++; end
        check("annul_no_ready", {63'd0, ready}, 64'd0);
        run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, W, 0);

        // Reset mid-BUSY at cycle 20
        @(negedge clk);
        signed_div = 1'b1; op1 = 32'd12345; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_ready", {63'd0, ready}, 64'd0);
        check("midrst_result", result, 64'd0);
        rst = 1'b0; start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", {63'd0, ready}, 64'd0);
        run_op(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, W, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

endmodule
